// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: assigns note events to synth voices (free first, else
// least-recently-allocated) and emits the per-voice register-write sequence.
module voice_allocator #(
  parameter int NUM_VOICES = 2,
  parameter int NOTE_WIDTH = 7
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_EventValid,
  output logic                  o_EventReady,
  input  logic                  i_EventNoteOn,
  input  logic [NOTE_WIDTH-1:0] i_EventNote,
  input  logic [23:0]           i_EventFrequency,
  output logic [7:0]            o_RegisterNumber,
  output logic [23:0]           o_RegisterValue,
  output logic                  o_RegisterWriteEnable,
  output logic [NUM_VOICES-1:0] o_VoiceActive
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WR_KEYOFF,
    S_WR_FREQ1,
    S_WR_FREQ2,
    S_WR_KEYON,
    S_WR_RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic                    ev_on_q, ev_on_d;
  logic [NOTE_WIDTH-1:0]   ev_note_q, ev_note_d;
  logic [23:0]             ev_freq_q, ev_freq_d;
  logic [VW-1:0]           voice_q, voice_d;
  logic [NUM_VOICES-1:0]   active_q, active_d;
  logic [NOTE_WIDTH-1:0]   vnote_q [NUM_VOICES];
  logic [NOTE_WIDTH-1:0]   vnote_d [NUM_VOICES];
  logic [VW-1:0]           rank_q  [NUM_VOICES];
  logic [VW-1:0]           rank_d  [NUM_VOICES];

  logic                    hit, free;
  logic [VW-1:0]           hit_idx, free_idx, oldest_idx;
  logic [3:0]              voice4;

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free       = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && (vnote_q[i] == ev_note_q)) begin
        hit     = 1'b1;
        hit_idx = VW'(i);
      end
      if (!active_q[i]) begin
        free     = 1'b1;
        free_idx = VW'(i);
      end
      if (rank_q[i] == '0) begin
        oldest_idx = VW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    ev_freq_d = ev_freq_q;
    voice_d   = voice_q;
    active_d  = active_q;
    vnote_d   = vnote_q;
    rank_d    = rank_q;
    case (state_q)
      S_IDLE: begin
        if (i_EventValid) begin
          ev_on_d   = i_EventNoteOn;
          ev_note_d = i_EventNote;
          ev_freq_d = i_EventFrequency;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (ev_on_q) begin
          if (hit) begin
            voice_d = hit_idx;
            state_d = S_WR_KEYOFF;
          end else if (free) begin
            voice_d = free_idx;
            state_d = S_WR_FREQ1;
          end else begin
            voice_d = oldest_idx;
            state_d = S_WR_KEYOFF;
          end
        end else if (hit) begin
          voice_d = hit_idx;
          state_d = S_WR_RELEASE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_KEYOFF: state_d = S_WR_FREQ1;
      S_WR_FREQ1:  state_d = S_WR_FREQ2;
      S_WR_FREQ2:  state_d = S_WR_KEYON;
      S_WR_KEYON: begin
        active_d[voice_q] = 1'b1;
        vnote_d[voice_q]  = ev_note_q;
        // Newest allocation moves to the top; everything above its old rank slides down.
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (rank_q[i] > rank_q[voice_q]) begin
            rank_d[i] = rank_q[i] - VW'(1);
          end
        end
        rank_d[voice_q] = VW'(NUM_VOICES - 1);
        state_d         = S_IDLE;
      end
      S_WR_RELEASE: begin
        active_d[voice_q] = 1'b0;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_freq_q <= '0;
      voice_q   <= '0;
      active_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnote_q[i] <= '0;
        rank_q[i]  <= VW'(i);
      end
    end else begin
      state_q   <= state_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      ev_freq_q <= ev_freq_d;
      voice_q   <= voice_d;
      active_q  <= active_d;
      vnote_q   <= vnote_d;
      rank_q    <= rank_d;
    end
  end

  assign voice4 = 4'(voice_q);

  // Outputs are gated by reset so an aborted sequence stops writing in the reset cycle.
  always_comb begin
    o_RegisterWriteEnable = 1'b0;
    o_RegisterNumber      = '0;
    o_RegisterValue       = '0;
    if (!i_Reset) begin
      case (state_q)
        S_WR_KEYOFF, S_WR_RELEASE: begin
          o_RegisterWriteEnable = 1'b1;
          o_RegisterNumber      = {voice4, 4'h5};
        end
        S_WR_FREQ1: begin
          o_RegisterWriteEnable = 1'b1;
          o_RegisterNumber      = {voice4, 4'h2};
          o_RegisterValue       = ev_freq_q;
        end
        S_WR_FREQ2: begin
          o_RegisterWriteEnable = 1'b1;
          o_RegisterNumber      = {voice4, 4'h4};
          o_RegisterValue       = ev_freq_q;
        end
        S_WR_KEYON: begin
          o_RegisterWriteEnable = 1'b1;
          o_RegisterNumber      = {voice4, 4'h5};
          o_RegisterValue       = 24'h000001;
        end
        default: ;
      endcase
    end
  end

  assign o_EventReady  = (state_q == S_IDLE) && !i_Reset;
  assign o_VoiceActive = i_Reset ? '0 : active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, stealing, release, retrigger and reset abort.
module tb_voice_allocator;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_EventValid;
  logic        o_EventReady;
  logic        i_EventNoteOn;
  logic [6:0]  i_EventNote;
  logic [23:0] i_EventFrequency;
  logic [7:0]  o_RegisterNumber;
  logic [23:0] o_RegisterValue;
  logic        o_RegisterWriteEnable;
  logic [1:0]  o_VoiceActive;

  int checks = 0;
  int errors = 0;

  always #5 i_Clock = ~i_Clock;

  voice_allocator #(.NUM_VOICES(2), .NOTE_WIDTH(7)) dut (
    .i_Clock              (i_Clock),
    .i_Reset              (i_Reset),
    .i_EventValid         (i_EventValid),
    .o_EventReady         (o_EventReady),
    .i_EventNoteOn        (i_EventNoteOn),
    .i_EventNote          (i_EventNote),
    .i_EventFrequency     (i_EventFrequency),
    .o_RegisterNumber     (o_RegisterNumber),
    .o_RegisterValue      (o_RegisterValue),
    .o_RegisterWriteEnable(o_RegisterWriteEnable),
    .o_VoiceActive        (o_VoiceActive)
  );

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  // Presents one event, waits (bounded) for ready, returns one cycle after the accepting edge.
  task automatic accept_event(input logic on, input logic [6:0] note, input logic [23:0] freq);
    int waited = 0;
    i_EventValid     = 1'b1;
    i_EventNoteOn    = on;
    i_EventNote      = note;
    i_EventFrequency = freq;
    while (!o_EventReady && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (o_EventReady !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: o_EventReady=%b after %0d cycles, required 1", o_EventReady, waited);
    end
    tick();
    i_EventValid = 1'b0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    i_EventValid = 1'b1;
    i_EventNoteOn = 1'b1;
    i_EventNote = 7'd10;
    i_EventFrequency = 24'h00abcd;
    tick();
    tick();
    checks++;
    if (o_EventReady !== 1'b0 || o_RegisterWriteEnable !== 1'b0 || o_RegisterNumber !== 8'h00 ||
        o_RegisterValue !== 24'h0 || o_VoiceActive !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b we=%b num=%h val=%h act=%b, required all 0",
               o_EventReady, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, o_VoiceActive);
    end
    i_EventValid = 1'b0;
    i_Reset = 1'b0;
    #1;
    checks++;
    if (o_EventReady !== 1'b1 || o_RegisterWriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b we=%b, required ready=1 we=0", o_EventReady, o_RegisterWriteEnable);
    end
  endtask

  task automatic test_first_note();
    logic [7:0]  en [3];
    logic [23:0] ev [3];
    en = '{8'h02, 8'h04, 8'h05};
    ev = '{24'h001000, 24'h001000, 24'h000001};
    accept_event(1'b1, 7'd60, 24'h001000);
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b0) begin
      errors++;
      $display("FAIL first_lookup: we=%b ready=%b, required 0 0", o_RegisterWriteEnable, o_EventReady);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== en[k] || o_RegisterValue !== ev[k] || o_EventReady !== 1'b0) begin
        errors++;
        $display("FAIL first_wr%0d: we=%b num=%h val=%h ready=%b, required we=1 num=%h val=%h ready=0",
                 k, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, o_EventReady, en[k], ev[k]);
      end
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_RegisterNumber !== 8'h00 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b01) begin
      errors++;
      $display("FAIL first_done: we=%b num=%h ready=%b act=%b, required 0 00 1 01",
               o_RegisterWriteEnable, o_RegisterNumber, o_EventReady, o_VoiceActive);
    end
  endtask

  task automatic test_second_note();
    logic [7:0]  en [3];
    logic [23:0] ev [3];
    en = '{8'h12, 8'h14, 8'h15};
    ev = '{24'h002000, 24'h002000, 24'h000001};
    accept_event(1'b1, 7'd64, 24'h002000);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== en[k] || o_RegisterValue !== ev[k]) begin
        errors++;
        $display("FAIL second_wr%0d: we=%b num=%h val=%h, required we=1 num=%h val=%h",
                 k, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, en[k], ev[k]);
      end
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b11) begin
      errors++;
      $display("FAIL second_done: we=%b ready=%b act=%b, required 0 1 11", o_RegisterWriteEnable, o_EventReady, o_VoiceActive);
    end
  endtask

  task automatic test_steal();
    logic [7:0]  en [4];
    logic [23:0] ev [4];
    en = '{8'h05, 8'h02, 8'h04, 8'h05};
    ev = '{24'h000000, 24'h003000, 24'h003000, 24'h000001};
    accept_event(1'b1, 7'd67, 24'h003000);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== en[k] || o_RegisterValue !== ev[k] || o_EventReady !== 1'b0) begin
        errors++;
        $display("FAIL steal_wr%0d: we=%b num=%h val=%h ready=%b, required we=1 num=%h val=%h ready=0",
                 k, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, o_EventReady, en[k], ev[k]);
      end
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b11) begin
      errors++;
      $display("FAIL steal_done: we=%b ready=%b act=%b, required 0 1 11", o_RegisterWriteEnable, o_EventReady, o_VoiceActive);
    end
  endtask

  task automatic test_note_off();
    accept_event(1'b0, 7'd64, 24'hffffff);
    checks++;
    if (o_RegisterWriteEnable !== 1'b0) begin
      errors++;
      $display("FAIL off_lookup: we=%b, required 0", o_RegisterWriteEnable);
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== 8'h15 || o_RegisterValue !== 24'h0 || o_EventReady !== 1'b0) begin
      errors++;
      $display("FAIL off_release: we=%b num=%h val=%h ready=%b, required 1 15 000000 0",
               o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, o_EventReady);
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b01) begin
      errors++;
      $display("FAIL off_done: we=%b ready=%b act=%b, required 0 1 01", o_RegisterWriteEnable, o_EventReady, o_VoiceActive);
    end
  endtask

  task automatic test_unheld_note_off();
    accept_event(1'b0, 7'd99, 24'h0);
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b0) begin
      errors++;
      $display("FAIL unheld_lookup: we=%b ready=%b, required 0 0", o_RegisterWriteEnable, o_EventReady);
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b01) begin
      errors++;
      $display("FAIL unheld_done: we=%b ready=%b act=%b, required 0 1 01", o_RegisterWriteEnable, o_EventReady, o_VoiceActive);
    end
  endtask

  task automatic test_retrigger();
    logic [7:0]  en [4];
    logic [23:0] ev [4];
    en = '{8'h05, 8'h02, 8'h04, 8'h05};
    ev = '{24'h000000, 24'h006000, 24'h006000, 24'h000001};
    accept_event(1'b1, 7'd67, 24'h006000);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== en[k] || o_RegisterValue !== ev[k]) begin
        errors++;
        $display("FAIL retrig_wr%0d: we=%b num=%h val=%h, required we=1 num=%h val=%h",
                 k, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, en[k], ev[k]);
      end
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b01) begin
      errors++;
      $display("FAIL retrig_done: we=%b ready=%b act=%b, required 0 1 01", o_RegisterWriteEnable, o_EventReady, o_VoiceActive);
    end
  endtask

  // Fill voice 1, then two steals must alternate voice 0 then voice 1.
  task automatic test_lru_rotation();
    logic [6:0]  notes [3];
    logic [23:0] freqs [3];
    int          nw    [3];
    logic [7:0]  en    [3][4];
    logic [23:0] ev    [3][4];
    notes = '{7'd70, 7'd72, 7'd74};
    freqs = '{24'h007000, 24'h00a000, 24'h00b000};
    nw    = '{3, 4, 4};
    en    = '{'{8'h12, 8'h14, 8'h15, 8'h00},
              '{8'h05, 8'h02, 8'h04, 8'h05},
              '{8'h15, 8'h12, 8'h14, 8'h15}};
    ev    = '{'{24'h007000, 24'h007000, 24'h000001, 24'h0},
              '{24'h000000, 24'h00a000, 24'h00a000, 24'h000001},
              '{24'h000000, 24'h00b000, 24'h00b000, 24'h000001}};
    for (int e = 0; e < 3; e++) begin
      accept_event(1'b1, notes[e], freqs[e]);
      for (int k = 0; k < nw[e]; k++) begin
        tick();
        checks++;
        if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== en[e][k] || o_RegisterValue !== ev[e][k]) begin
          errors++;
          $display("FAIL lru_ev%0d_wr%0d: we=%b num=%h val=%h, required we=1 num=%h val=%h",
                   e, k, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, en[e][k], ev[e][k]);
        end
      end
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b11) begin
        errors++;
        $display("FAIL lru_ev%0d_done: we=%b ready=%b act=%b, required 0 1 11",
                 e, o_RegisterWriteEnable, o_EventReady, o_VoiceActive);
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [7:0]  en [3];
    logic [23:0] ev [3];
    en = '{8'h05, 8'h02, 8'h04};
    ev = '{24'h000000, 24'h009000, 24'h009000};
    accept_event(1'b1, 7'd76, 24'h009000);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== en[k] || o_RegisterValue !== ev[k]) begin
        errors++;
        $display("FAIL abort_wr%0d: we=%b num=%h val=%h, required we=1 num=%h val=%h",
                 k, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, en[k], ev[k]);
      end
    end
    i_Reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b0 || o_RegisterNumber !== 8'h00 || o_RegisterValue !== 24'h0 ||
          o_VoiceActive !== 2'b00 || o_EventReady !== 1'b0) begin
        errors++;
        $display("FAIL abort_reset%0d: we=%b num=%h val=%h act=%b ready=%b, required all 0",
                 c, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, o_VoiceActive, o_EventReady);
      end
    end
    i_Reset = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (o_RegisterWriteEnable !== 1'b0 || o_VoiceActive !== 2'b00 || o_EventReady !== 1'b1) begin
        errors++;
        $display("FAIL abort_idle%0d: we=%b act=%b ready=%b, required 0 00 1",
                 c, o_RegisterWriteEnable, o_VoiceActive, o_EventReady);
      end
      tick();
    end
    en = '{8'h02, 8'h04, 8'h05};
    ev = '{24'h005000, 24'h005000, 24'h000001};
    accept_event(1'b1, 7'd80, 24'h005000);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_RegisterWriteEnable !== 1'b1 || o_RegisterNumber !== en[k] || o_RegisterValue !== ev[k]) begin
        errors++;
        $display("FAIL post_reset_wr%0d: we=%b num=%h val=%h, required we=1 num=%h val=%h",
                 k, o_RegisterWriteEnable, o_RegisterNumber, o_RegisterValue, en[k], ev[k]);
      end
    end
    tick();
    checks++;
    if (o_RegisterWriteEnable !== 1'b0 || o_EventReady !== 1'b1 || o_VoiceActive !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_done: we=%b ready=%b act=%b, required 0 1 01", o_RegisterWriteEnable, o_EventReady, o_VoiceActive);
    end
  endtask

  initial begin
    i_Reset          = 1'b1;
    i_EventValid     = 1'b0;
    i_EventNoteOn    = 1'b0;
    i_EventNote      = '0;
    i_EventFrequency = '0;
    test_reset();
    test_first_note();
    test_second_note();
    test_steal();
    test_note_off();
    test_unheld_note_off();
    test_retrigger();
    test_lru_rotation();
    test_reset_mid_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
